// File: rtl/conv3x3_mac_pkg.sv
// Shared types and sizing for the 3x3 convolution MAC.
// Operand widths default to the tensor assembler's output format.
package conv_pkg;

  localparam int WIDTH_DEF = 17;
  localparam int KW_W_DEF  = 8;
  localparam int N_TAPS    = 9;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } conv_state_t;

  function automatic int acc_width(
    input int w,
    input int k
  );
    return w + k + 4;
  endfunction

endpackage

// File: rtl/conv3x3_mac_if.sv
// Operand/result handshake bundle for conv3x3_mac.
// master drives operands and consumes results; slave is the MAC.
interface conv3x3_mac_if
  import conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int KW_W  = KW_W_DEF,
  localparam int ACC_W = acc_width(WIDTH, KW_W)
);

  logic [2:0][2:0][WIDTH-1:0] tensor_in;
  logic [2:0][2:0][KW_W-1:0]  kernel_in;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [ACC_W-1:0]    out_data;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output tensor_in,
    output kernel_in,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  tensor_in,
    input  kernel_in,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/conv3x3_mac_mac_unit.sv
// Signed multiply-accumulate register with synchronous clear.
// Products are sign-extended into the guard-banded accumulator.
module mac_unit #(
  parameter int WIDTH = 17,
  parameter int KW_W  = 8,
  parameter int ACC_W = WIDTH + KW_W + 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [KW_W-1:0]  b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PW = WIDTH + KW_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv3x3_mac.sv
// Sequential 3x3 signed dot product, one tap per clock.
// Operands are snapshotted on accept; result held until taken.
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int KW_W  = KW_W_DEF,
  localparam int ACC_W = acc_width(WIDTH, KW_W)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic signed [2:0][2:0][WIDTH-1:0] tensor_in,
  input  logic signed [2:0][2:0][KW_W-1:0]  kernel_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic signed [ACC_W-1:0]           out_data,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam logic [3:0] LAST_IDX = 4'(N_TAPS - 1);

  typedef logic [N_TAPS-1:0][WIDTH-1:0] taps_t;
  typedef logic [N_TAPS-1:0][KW_W-1:0]  coefs_t;

  conv_state_t state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  taps_t       snap_t_q, snap_t_d, t_flat;
  coefs_t      snap_k_q, snap_k_d, k_flat;
  logic        out_valid_q, out_valid_d;
  logic        load, clr, en;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        t_flat[3*r+c] = tensor_in[r][c];
        k_flat[3*r+c] = kernel_in[r][c];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    load        = 1'b0;
    clr         = 1'b0;
    en          = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      MAC: begin
        en = 1'b1;
        if (idx_q == LAST_IDX) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          load        = in_valid;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      clr     = 1'b1;
      idx_d   = '0;
      state_d = MAC;
    end
    snap_t_d = load ? t_flat : snap_t_q;
    snap_k_d = load ? k_flat : snap_k_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_t_q    <= '0;
      snap_k_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_t_q    <= snap_t_d;
      snap_k_q    <= snap_k_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The accumulator doubles as the output register: it is frozen in DONE.
  mac_unit #(
    .WIDTH (WIDTH),
    .KW_W  (KW_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (en),
    .a     (snap_t_q[idx_q]),
    .b     (snap_k_q[idx_q]),
    .acc   (out_data)
  );

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed and table-driven checks for conv3x3_mac.
// Expected values come from hand arithmetic or a local dot model.
module tb_conv3x3_mac;

  localparam int W = 17;
  localparam int K = 8;

  typedef logic [2:0][2:0][W-1:0] ten_t;
  typedef logic [2:0][2:0][K-1:0] ker_t;

  typedef struct {
    string  name;
    int     t;
    int     k;
    longint exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  conv3x3_mac_if #(.WIDTH(W), .KW_W(K)) bus ();

  conv3x3_mac #(.WIDTH(W), .KW_W(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tensor_in (bus.tensor_in),
    .kernel_in (bus.kernel_in),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint dot(input ten_t t, input ker_t k);
    longint s = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        s += longint'($signed(t[r][c])) * longint'($signed(k[r][c]));
      end
    end
    return s;
  endfunction

  task automatic set_ops(input int t, input int k);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        bus.tensor_in[r][c] = W'(t);
        bus.kernel_in[r][c] = K'(k);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(output int n);
    int g = 0;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("send_ready", longint'(bus.in_ready), 1);
    n = cyc;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input longint exp,
                          input int n);
    int g = 0;
    while (!bus.out_valid && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk({name, "_valid"}, longint'(bus.out_valid), 1);
    chk({name, "_data"}, longint'(bus.out_data), exp);
    chk({name, "_lat"}, longint'(cyc - n), 10);
  endtask

  vec_t vecs[6];
  ten_t st[20];
  ker_t sk[20];
  longint sexp[20];

  initial begin
    int n;
    int sptr;
    int rptr;
    int last;
    int g;
    logic take;

    vecs[0] = '{"ones", 1, 1, 9};
    vecs[1] = '{"max_pos", 65535, 127, 74906505};
    vecs[2] = '{"neg_neg", -65536, -128, 75497472};
    vecs[3] = '{"neg_pos", -65536, 127, -74907648};
    vecs[4] = '{"twos", 2, 2, 36};
    vecs[5] = '{"mixed", -3, 5, -135};

    bus.tensor_in = '0;
    bus.kernel_in = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_ops(vecs[i].t, vecs[i].k);
      send(n);
      wait_res(vecs[i].name, vecs[i].exp, n);
      @(negedge clk);
      chk({vecs[i].name, "_pulse"}, longint'(bus.out_valid), 0);
    end

    // Identity kernel; tensor scrambled right after acceptance.
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        bus.tensor_in[r][c] = W'($urandom);
        bus.kernel_in[r][c] = '0;
      end
    end
    bus.tensor_in[1][1] = W'(-5);
    bus.kernel_in[1][1] = K'(1);
    send(n);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        bus.tensor_in[r][c] = W'($urandom);
        bus.kernel_in[r][c] = K'($urandom);
      end
    end
    wait_res("ident", -5, n);

    // Backpressure with a pending request, then back-to-back accept.
    @(negedge clk);
    set_ops(1, 3);
    bus.out_ready = 1'b0;
    send(n);
    wait_res("bp1", 27, n);
    set_ops(3, 3);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", longint'(bus.in_ready), 0);
      @(negedge clk);
      chk("bp_hold_valid", longint'(bus.out_valid), 1);
      chk("bp_hold_data", longint'(bus.out_data), 27);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", longint'(bus.in_ready), 1);
    n = cyc;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_drop_valid", longint'(bus.out_valid), 0);
    wait_res("bp2", 81, n);

    // Asynchronous reset at idx 4 of a MAC.
    @(negedge clk);
    set_ops(1, 1);
    send(n);
    repeat (4) @(negedge clk);
    chk("pre_rst_acc", longint'(bus.out_data), 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(bus.out_valid), 0);
    chk("mid_rst_data", longint'(bus.out_data), 0);
    chk("mid_rst_ready", longint'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", longint'(bus.in_ready), 1);
    @(negedge clk);
    set_ops(2, 2);
    send(n);
    wait_res("after_rst", 36, n);

    // Streaming with both handshakes held high.
    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          st[i][r][c] = W'($urandom);
          sk[i][r][c] = K'($urandom);
        end
      end
      sexp[i] = dot(st[i], sk[i]);
    end
    sptr = 0;
    rptr = 0;
    last = 0;
    g = 0;
    bus.out_ready = 1'b1;
    while (rptr < 20 && g < 400) begin
      @(negedge clk);
      g++;
      if (bus.out_valid) begin
        chk("stream_data", longint'(bus.out_data), sexp[rptr]);
        if (rptr > 0) begin
          chk("stream_gap", longint'(cyc - last), 10);
        end
        last = cyc;
        rptr++;
      end
      if (sptr < 20) begin
        bus.tensor_in = st[sptr];
        bus.kernel_in = sk[sptr];
        bus.in_valid  = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      take = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (take) sptr++;
    end
    bus.in_valid = 1'b0;
    chk("stream_count", longint'(rptr), 20);
    chk("stream_sent", longint'(sptr), 20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Downstream consumer of the 3x3 tensor assembler.
- Accepts a complete 3x3 tensor of signed samples plus a 3x3 signed kernel through a valid/ready handshake.
- Computes the full-precision dot product sequentially, one multiply-accumulate per clock.
- Presents the result through a valid/ready output handshake, so the upstream stage can refill its tensor while a result is pending.

Parameters:
- WIDTH, 17: signed tensor element width (matches tensor assembler output).
- KW_W, 8: signed kernel coefficient width.
- ACC_W, WIDTH+KW_W+4: accumulator/result width. Derived, not to be overridden; 4 guard bits cover 9 products.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tensor_in  in  [2:0][2:0] x WIDTH  signed samples, indexed [row][col].
- kernel_in  in  [2:0][2:0] x KW_W  signed coefficients, indexed [row][col].
- in_valid  in  1  tensor_in/kernel_in are valid.
- in_ready  out  1  block can accept an operand set this cycle.
- out_data  out  ACC_W  signed dot product.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Assertion of rst_n (low) at any time, including mid-MAC: state=IDLE, acc=0, idx=0, out_data=0, out_valid=0, in_ready=1 (in_ready is combinational from state), snapshot registers cleared.
- States IDLE, MAC, DONE. Transitions:
  - IDLE: in_ready=1. When in_valid, capture tensor_in and kernel_in into snapshot registers, acc<=0, idx<=0, go to MAC.
  - MAC: in_ready=0; in_valid is ignored. Each cycle: acc <= acc + snap_t[idx] * snap_k[idx], with row-major idx (0..8, idx=3*row+col). At idx==8, load out_data with the final sum, set out_valid<=1, go to DONE. Otherwise idx<=idx+1.
  - DONE: out_valid=1, out_data held stable. When out_ready:
    - out_valid<=0.
    - If in_valid is also high the same cycle, accept the new operand set and go directly to MAC (back-to-back).
    - Otherwise go to IDLE.
  - DONE in_ready rule: in_ready = out_ready, combinational.
- Latency: handshake accepted at cycle N; out_valid first high at cycle N+10 (9 MAC cycles plus output register). Throughput: one result per 10 cycles with out_ready held high.
- Arithmetic: two's-complement signed throughout. Products are WIDTH+KW_W bits, sign-extended to ACC_W. No saturation and no overflow are possible by construction.
- Snapshot: the operands used are exactly those present on the accepting handshake cycle. Changes to tensor_in/kernel_in afterwards have no effect on the in-flight result.
- While out_valid=1 and out_ready=0: out_data and out_valid are held indefinitely.
- in_valid may drop without acceptance; there is no requirement for the upstream stage to hold it.

Decomposition:
- Package conv_pkg:
  - default WIDTH, KW_W.
  - function acc_width(w,k) returning w+k+4.
  - enum type conv_state_t {IDLE, MAC, DONE}.
  - localparam N_TAPS=9.
- Sub-module mac_unit:
  - signed multiply-accumulate register with clear and enable.
  - ports clk, rst_n, clr, en, a[WIDTH], b[KW_W], acc[ACC_W].
- Top level holds the FSM, idx counter, snapshot registers, output register and handshake logic.

Test Plan:
- All tensor=1, all kernel=1, out_ready=1 -> out_data=9, out_valid rises exactly 10 cycles after acceptance, pulses 1 cycle.
- Extreme values:
  - tensor all 65535, kernel all 127 -> 74906505.
  - tensor all -65536, kernel all -128 -> 75497472.
  - tensor all -65536, kernel all 127 -> -74907648.
- Identity kernel (center 1, others 0), tensor[1][1]=-5, other taps random -> out_data=-5. Change tensor_in the cycle after acceptance -> result still -5.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, in_valid ignored. Then out_ready=1 with in_valid=1 -> new set accepted the same cycle, next result 10 cycles later.
- Reset mid-MAC: assert rst_n=0 at MAC idx=4 -> out_valid=0 and out_data=0 immediately (asynchronous), in_ready=1 after release. Next operation with all-2 tensor/kernel -> 36.
- Continuous streaming: 20 random operand sets with in_valid and out_ready held high -> results match the reference model in order, one every 10 cycles, no drops.
